fp_to_int: RTL and testbench

//  Multi-cycle IEEE-754 single-precision to 32-bit signed integer converter.
//  - Decode direction of the fp datapath: the adder packs {sign,exp,mantis} words; this block unpacks them.
//  - Sits between fp result producers and integer consumers.
//  - Valid/ready on both sides; iterative shifter, not a barrel.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_to_int_if.sv | 24 ++
 rtl/fp_classify.sv | 26 ++
 rtl/fp_to_int.sv | 143 ++++++++++++++
 tb/tb_fp_to_int.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point datapath.
// Used by the fp_to_int converter and the fp_classify front end.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // The one float of magnitude 2^31 that fits the integer range: -2^31.
    localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

    typedef enum logic {
        RM_TRUNC = 1'b0,
        RM_RNE   = 1'b1
    } round_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } state_e;

    function automatic logic [31:0] saturate(input logic sign);
        return sign ? INT_MIN : INT_MAX;
    endfunction

endpackage

// File: rtl/fp_to_int_if.sv
// Operand and result handshakes of the float-to-int converter.
// master = producer/consumer side, slave = converter side.
interface fp_to_int_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_int;
    logic        invalid;
    logic        inexact;

    modport master (
        output in_valid, in_float, res_ready,
        input  in_ready, res_valid, res_int, invalid, inexact
    );

    modport slave (
        input  in_valid, in_float, res_ready,
        output in_ready, res_valid, res_int, invalid, inexact
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational unpack of a single-precision word into fields and class flags.
// Shared with the adder front end.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]          in_float,
    output logic                 is_nan,
    output logic                 is_inf,
    output logic                 is_zero_or_denorm,
    output logic signed [8:0]    unbiased_exp,
    output logic                 sign,
    output logic [FP_MAN_W-1:0]  mantis
);

    logic [FP_EXP_W-1:0] exp_field;

    assign sign      = in_float[31];
    assign exp_field = in_float[30:23];
    assign mantis    = in_float[22:0];

    assign is_nan            = (&exp_field) && (|mantis);
    assign is_inf            = (&exp_field) && !(|mantis);
    assign is_zero_or_denorm = (exp_field == '0);
    assign unbiased_exp      = $signed({1'b0, exp_field}) - $signed(9'(FP_BIAS));

endmodule

// File: rtl/fp_to_int.sv
// Iterative IEEE-754 single to int32 converter: specials resolve at accept,
// normals shift left SHIFT_STEP bits per cycle, then round and negate.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 4,
    parameter int ROUND_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    fp_to_int_if.slave bus
);

    localparam logic [4:0]  STEP  = 5'(SHIFT_STEP);
    localparam round_mode_e RMODE = round_mode_e'(ROUND_MODE[0]);
    localparam bit          RNE   = (RMODE == RM_RNE);

    state_e      state, state_next;
    logic [55:0] work, work_next;
    logic [4:0]  rem, rem_next;
    logic        sign_q, sign_next;
    logic [31:0] res_q, res_next;
    logic        invalid_q, invalid_next;
    logic        inexact_q, inexact_next;

    logic                c_nan, c_inf, c_zd, c_sign;
    logic signed [8:0]   c_exp;
    logic [FP_MAN_W-1:0] c_man;

    fp_classify u_classify (
        .in_float          (bus.in_float),
        .is_nan            (c_nan),
        .is_inf            (c_inf),
        .is_zero_or_denorm (c_zd),
        .unbiased_exp      (c_exp),
        .sign              (c_sign),
        .mantis            (c_man)
    );

    logic [4:0]  step_amt;
    logic        round_up;
    logic [31:0] mag_round;
    logic [31:0] early_mag;

    assign step_amt  = (rem < STEP) ? rem : STEP;
    assign round_up  = RNE && work[23] && ((|work[22:0]) || work[24]);
    assign mag_round = work[55:24] + {31'b0, round_up};
    // Only values in (0.5, 1) round up to one; 0.5 itself ties to even zero.
    assign early_mag = (RNE && (c_exp == -9'sd1) && (|c_man)) ? 32'd1 : 32'd0;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        work_next    = work;
        rem_next     = rem;
        sign_next    = sign_q;
        res_next     = res_q;
        invalid_next = invalid_q;
        inexact_next = inexact_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_next    = c_sign;
                    invalid_next = 1'b0;
                    inexact_next = 1'b0;
                    state_next   = DONE;
                    if (c_nan) begin
                        res_next     = INT_MIN;
                        invalid_next = 1'b1;
                    end else if (c_inf) begin
                        res_next     = saturate(c_sign);
                        invalid_next = 1'b1;
                    end else if (c_exp >= 9'sd31) begin
                        if (bus.in_float == FP_NEG_2P31) begin
                            res_next = INT_MIN;
                        end else begin
                            res_next     = saturate(c_sign);
                            invalid_next = 1'b1;
                        end
                    end else if (c_zd) begin
                        res_next     = '0;
                        inexact_next = |c_man;
                    end else if (c_exp < 9'sd0) begin
                        res_next     = c_sign ? -early_mag : early_mag;
                        inexact_next = 1'b1;
                    end else begin
                        work_next  = {31'b0, 1'b1, c_man, 1'b0};
                        rem_next   = c_exp[4:0];
                        state_next = (c_exp == 9'sd0) ? ROUND : SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_next = work << step_amt;
                rem_next  = rem - step_amt;
                if (rem == step_amt) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                res_next     = sign_q ? -mag_round : mag_round;
                inexact_next = |work[23:0];
                invalid_next = 1'b0;
                state_next   = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the datapath is reset too so no X reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            rem       <= '0;
            sign_q    <= 1'b0;
            res_q     <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state     <= state_next;
            work      <= work_next;
            rem       <= rem_next;
            sign_q    <= sign_next;
            res_q     <= res_next;
            invalid_q <= invalid_next;
            inexact_q <= inexact_next;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.res_int   = res_q;
    assign bus.invalid   = invalid_q;
    assign bus.inexact   = inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Bench: a truncating (step 4) and an RNE (step 3) converter fed identical
// operands and compared against an arithmetic reference model.
module tb_fp_to_int;

    localparam int STEP_T = 4;
    localparam int STEP_R = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    fp_to_int_if bus_t ();
    fp_to_int_if bus_r ();

    fp_to_int #(.SHIFT_STEP(STEP_T), .ROUND_MODE(0)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    fp_to_int #(.SHIFT_STEP(STEP_R), .ROUND_MODE(1)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        invalid;
        logic        inexact;
        int          lat;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Value-level reference: integer part and discarded fraction by plain arithmetic.
    function automatic exp_t model(input logic [31:0] x, input bit rne, input int step);
        exp_t   r;
        logic   s;
        int     ex, e, d;
        longint mant, mag, frac, half;
        s    = x[31];
        ex   = int'(x[30:23]);
        e    = ex - 127;
        mant = longint'({1'b1, x[22:0]});
        r.res = 32'h0;
        r.invalid = 1'b0;
        r.inexact = 1'b0;
        r.lat = 1;
        if (ex == 255) begin
            r.invalid = 1'b1;
            r.res = (x[22:0] != 0 || s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (x == 32'hCF00_0000) begin
            r.res = 32'h8000_0000;
        end else if (e >= 31) begin
            r.invalid = 1'b1;
            r.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (ex == 0) begin
            r.inexact = (x[22:0] != 0);
        end else if (e < -1) begin
            r.inexact = 1'b1;
        end else begin
            if (e >= 23) begin
                mag  = mant << (e - 23);
                frac = 0;
            end else begin
                d    = 23 - e;
                mag  = mant >> d;
                frac = mant & ((longint'(1) << d) - 1);
                half = longint'(1) << (d - 1);
                if (rne && (frac > half || (frac == half && mag[0]))) mag++;
            end
            r.inexact = (frac != 0);
            r.res = s ? 32'(-mag) : 32'(mag);
            if (e >= 0) r.lat = 2 + (e + step - 1) / step;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] f);
        bus_t.in_valid = v;
        bus_r.in_valid = v;
        bus_t.in_float = f;
        bus_r.in_float = f;
    endtask

    task automatic set_ready(input logic r);
        bus_t.res_ready = r;
        bus_r.res_ready = r;
    endtask

    task automatic check_dut(input string who, input logic [31:0] x, input exp_t e,
                             input logic [31:0] ri, input logic inv, input logic inx,
                             input logic rv, input logic ir);
        check($sformatf("%s %08h res", who, x), ri, e.res);
        check($sformatf("%s %08h invalid", who, x), 32'(inv), 32'(e.invalid));
        check($sformatf("%s %08h inexact", who, x), 32'(inx), 32'(e.inexact));
        check($sformatf("%s %08h res_valid", who, x), 32'(rv), 32'd1);
        check($sformatf("%s %08h in_ready_busy", who, x), 32'(ir), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " trunc res_valid"}, 32'(bus_t.res_valid), 32'd0);
        check({tag, " trunc in_ready"},  32'(bus_t.in_ready),  32'd1);
        check({tag, " rne res_valid"},   32'(bus_r.res_valid), 32'd0);
        check({tag, " rne in_ready"},    32'(bus_r.in_ready),  32'd1);
    endtask

    task automatic run(input logic [31:0] x, input int hold);
        exp_t et, er;
        int   lat_t, lat_r;
        et = model(x, 1'b0, STEP_T);
        er = model(x, 1'b1, STEP_R);
        @(negedge clk);
        check($sformatf("trunc %08h in_ready", x), 32'(bus_t.in_ready), 32'd1);
        check($sformatf("rne %08h in_ready", x),   32'(bus_r.in_ready), 32'd1);
        drive(1'b1, x);
        @(posedge clk);
        #1 drive(1'b1, $urandom);
        lat_t = 0;
        lat_r = 0;
        for (int cyc = 1; cyc <= 40 && (lat_t == 0 || lat_r == 0); cyc++) begin
            @(negedge clk);
            if (lat_t == 0 && bus_t.res_valid) lat_t = cyc;
            if (lat_r == 0 && bus_r.res_valid) lat_r = cyc;
            drive(1'b1, $urandom);
        end
        check($sformatf("trunc %08h latency", x), 32'(lat_t), 32'(et.lat));
        check($sformatf("rne %08h latency", x),   32'(lat_r), 32'(er.lat));
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check_dut("trunc", x, et, bus_t.res_int, bus_t.invalid, bus_t.inexact,
                      bus_t.res_valid, bus_t.in_ready);
            check_dut("rne", x, er, bus_r.res_int, bus_r.invalid, bus_r.inexact,
                      bus_r.res_valid, bus_r.in_ready);
            drive(1'b1, $urandom);
        end
        drive(1'b0, $urandom);
        set_ready(1'b1);
        @(posedge clk);
        #1 set_ready(1'b0);
        @(negedge clk);
        check_idle($sformatf("%08h release", x));
    endtask

    logic [31:0] directed [16] = '{
        32'hC2F6E979, 32'h3F000000, 32'h3FC00000, 32'h40200000,
        32'h40490FDB, 32'hCF000000, 32'h4F000000, 32'h7FC00000,
        32'hFF800000, 32'h00000001, 32'h80000000, 32'hBF000000,
        32'hBF400000, 32'h3F7FFFFF, 32'h4B000001, 32'hCB7FFFFF
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        int          r;
        drive(1'b0, 32'h0);
        set_ready(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset trunc res_int", bus_t.res_int, 32'h0);
        check("reset trunc invalid", 32'(bus_t.invalid), 32'd0);
        check("reset trunc inexact", 32'(bus_t.inexact), 32'd0);
        check("reset rne res_int",   bus_r.res_int, 32'h0);
        check("reset rne invalid",   32'(bus_r.invalid), 32'd0);
        check("reset rne inexact",   32'(bus_r.inexact), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (directed[i]) run(directed[i], 0);
        run(32'h4EFFFFFF, 5);

        // Reset while both converters are still shifting a large operand.
        @(negedge clk);
        drive(1'b1, 32'h4EFFFFFF);
        @(posedge clk);
        #1 drive(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("abort");
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_idle("abort later");
        run(32'h3F800000, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                x = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
            end else if (r < 8) begin
                x = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                     ($urandom_range(0, 2) == 0) ? 23'h0 : 23'($urandom)};
            end else begin
                x = $urandom;
            end
            run(x, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
